// File: rtl/bsg_alu_arbiter_if.sv
// Request/result bundle for bsg_alu_arbiter.
// The requester/consumer side holds the master modport; the arbiter holds
// the slave modport. Signal names keep the arbiter-relative _i/_o suffixes.
interface bsg_alu_arbiter_if #(
    parameter int width_p = 8,
    parameter int els_p   = 4
);
    localparam int id_width = (els_p > 1) ? $clog2(els_p) : 1;

    logic [els_p-1:0]         v_i;
    logic [2*els_p-1:0]       op_i;
    logic [width_p*els_p-1:0] a_i;
    logic [width_p*els_p-1:0] b_i;
    logic [els_p-1:0]         ready_o;
    logic                     v_o;
    logic [width_p-1:0]       res_o;
    logic [id_width-1:0]      id_o;
    logic                     yumi_i;

    modport master (
        output v_i, op_i, a_i, b_i, yumi_i,
        input  ready_o, v_o, res_o, id_o
    );

    modport slave (
        input  v_i, op_i, a_i, b_i, yumi_i,
        output ready_o, v_o, res_o, id_o
    );
endinterface

// File: rtl/bsg_alu_arbiter.sv
// Round-robin arbiter sharing one 2-bit-opcode ALU between els_p requesters.
// The winner's operands go through the ALU combinationally and the result is
// captured in a single-entry output register tagged with the winner's id.
// Output handshake is valid/yumi; a yumi in the same cycle as a new accept
// replaces the entry without a bubble.
module bsg_alu_arbiter #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bsg_alu_arbiter_if.slave       bus
);
    localparam int id_width = (els_p > 1) ? $clog2(els_p) : 1;

    // Opcodes: 00 AND, 01 XOR, 10 NAND, 11 ADD (carry-out dropped).
    function automatic logic [width_p-1:0] alu_f(
        input logic [1:0]         op,
        input logic [width_p-1:0] a,
        input logic [width_p-1:0] b
    );
        logic [width_p-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a ^ b;
            2'b10:   r = ~(a & b);
            default: r = a + b;
        endcase
        return r;
    endfunction

    logic                v_q, v_d;
    logic [width_p-1:0]  res_q, res_d;
    logic [id_width-1:0] id_q, id_d;
    logic [id_width-1:0] last_q, last_d;

    logic                grant_found;
    logic [id_width-1:0] grant_idx;
    logic                accept;
    logic [1:0]          op_sel;
    logic [width_p-1:0]  a_sel;
    logic [width_p-1:0]  b_sel;

    // Round-robin search starting just after the last winner, wrapping at els_p.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 1; i <= els_p; i++) begin
            idx = int'(last_q) + i;
            if (idx >= els_p) idx = idx - els_p;
            if (!grant_found && bus.v_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = id_width'(idx);
            end
        end
    end

    // Accept when the output slot is free (or being drained) and someone asks;
    // the winner's operands are muxed to the ALU.
    always_comb begin
        int gi;
        gi          = int'(grant_idx);
        accept      = (~v_q | bus.yumi_i) & grant_found & ~reset_i;
        bus.ready_o = accept ? (els_p'(1) << grant_idx) : '0;
        op_sel      = bus.op_i[2*gi +: 2];
        a_sel       = bus.a_i[gi*width_p +: width_p];
        b_sel       = bus.b_i[gi*width_p +: width_p];
    end

    // Next state of the output slot and the last-grant pointer.
    always_comb begin
        v_d    = v_q;
        res_d  = res_q;
        id_d   = id_q;
        last_d = last_q;
        if (accept) begin
            v_d    = 1'b1;
            res_d  = alu_f(op_sel, a_sel, b_sel);
            id_d   = grant_idx;
            last_d = grant_idx;
        end else if (bus.yumi_i) begin
            v_d = 1'b0;
        end
    end

    // State registers; reset empties the slot and gives requester 0 top priority.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            res_q  <= '0;
            id_q   <= '0;
            last_q <= id_width'(els_p - 1);
        end else begin
            v_q    <= v_d;
            res_q  <= res_d;
            id_q   <= id_d;
            last_q <= last_d;
        end
    end

    assign bus.v_o   = v_q;
    assign bus.res_o = res_q;
    assign bus.id_o  = id_q;

`ifndef SYNTHESIS
    // Consumer must not take a result that is not there.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(bus.yumi_i && !v_q))
                else $error("bsg_alu_arbiter: yumi_i asserted while v_o=0");
        end
    end
`endif
endmodule

// File: tb/tb_bsg_alu_arbiter.sv
// Scoreboard bench for bsg_alu_arbiter (width_p=8, els_p=4).
module tb_bsg_alu_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        logic [1:0] id;
        logic [7:0] res;
    } exp_t;

    logic clk;
    logic reset;
    logic [N-1:0] v_drv;
    logic         yumi_drv;
    logic [1:0]   op_arr [N];
    logic [7:0]   a_arr  [N];
    logic [7:0]   b_arr  [N];

    exp_t sb [$];
    int   last_m;
    int   n_checks;
    int   n_fail;

    bsg_alu_arbiter_if #(.width_p(W), .els_p(N)) bus ();

    bsg_alu_arbiter #(.width_p(W), .els_p(N)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.v_i    = v_drv;
        bus.yumi_i = yumi_drv;
        bus.op_i   = '0;
        bus.a_i    = '0;
        bus.b_i    = '0;
        for (int k = 0; k < N; k++) begin
            bus.op_i[2*k +: 2] = op_arr[k];
            bus.a_i[k*W +: W]  = a_arr[k];
            bus.b_i[k*W +: W]  = b_arr[k];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            2'b00:   return a & b;
            2'b01:   return a ^ b;
            2'b10:   return ~(a & b);
            default: return s[7:0];
        endcase
    endfunction

    // One clock: drive at negedge, check outputs and grant, update scoreboard at posedge.
    task automatic step(input logic [N-1:0] vv, input logic want_yumi, input logic rst);
        logic       yumi_eff;
        logic       found;
        int         g;
        logic [3:0] exp_ready;
        exp_t       e;
        yumi_eff = want_yumi && (sb.size() != 0);
        v_drv    = vv;
        yumi_drv = yumi_eff;
        reset    = rst;
        #1;
        chk("v_o", 32'(bus.v_o), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("res_o", 32'(bus.res_o), 32'(sb[0].res));
            chk("id_o", 32'(bus.id_o), 32'(sb[0].id));
        end
        found     = 1'b0;
        g         = 0;
        exp_ready = '0;
        if (!rst && (sb.size() == 0 || yumi_eff)) begin
            for (int i = 1; i <= N; i++) begin
                int idx;
                idx = (last_m + i) % N;
                if (!found && vv[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        if (found) exp_ready[g] = 1'b1;
        chk("ready_o", 32'(bus.ready_o), 32'(exp_ready));
        @(posedge clk);
        if (rst) begin
            sb.delete();
            last_m = N - 1;
        end else begin
            if (yumi_eff) void'(sb.pop_front());
            if (found) begin
                e.id  = 2'(g);
                e.res = alu_ref(op_arr[g], a_arr[g], b_arr[g]);
                sb.push_back(e);
                last_m = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_operands();
        for (int k = 0; k < N; k++) begin
            op_arr[k] = 2'($urandom_range(0, 3));
            a_arr[k]  = 8'($urandom_range(0, 255));
            b_arr[k]  = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        logic [7:0] lit [4];
        lit[0] = 8'h30; lit[1] = 8'hCC; lit[2] = 8'hCF; lit[3] = 8'h2C;
        n_checks = 0;
        n_fail   = 0;
        last_m   = N - 1;
        reset    = 1'b1;
        v_drv    = '1;
        yumi_drv = 1'b0;
        rand_operands();
        @(negedge clk);

        // Reset held 3 cycles with every requester asking.
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        chk("first_grant_id", 32'(bus.id_o), 32'd0);

        // Opcodes on requester 1: a=F0, b=3C.
        for (int k = 0; k < 4; k++) begin
            rand_operands();
            op_arr[1] = 2'(k);
            a_arr[1]  = 8'hF0;
            b_arr[1]  = 8'h3C;
            step(4'b0010, 1'b1, 1'b0);
            chk("op_lit_res", 32'(bus.res_o), 32'(lit[k]));
            chk("op_lit_id", 32'(bus.id_o), 32'd1);
        end

        // Round robin with continuous consumption; pointer is at 1 here.
        for (int i = 0; i < 12; i++) begin
            rand_operands();
            step(4'b1111, 1'b1, 1'b0);
            chk("rr_id", 32'(bus.id_o), 32'((2 + i) % N));
        end

        // Backpressure: hold 5 cycles, then take and reload.
        for (int i = 0; i < 5; i++) begin
            rand_operands();
            step(4'b1111, 1'b0, 1'b0);
        end
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Skip idle requesters: last grant 1, then v_i=1001.
        step(4'b0000, 1'b0, 1'b1);
        rand_operands();
        step(4'b0010, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b0);
        chk("skip_id_3", 32'(bus.id_o), 32'd3);
        step(4'b1001, 1'b1, 1'b0);
        chk("skip_id_0", 32'(bus.id_o), 32'd0);

        // Reset while a result is held; nothing may reappear afterwards.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rand_operands();
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
